// File: rtl/div_32_pkg.sv
// Shared types and constants for the div_32 restoring divider.
package div_32_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_32_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_32_step
    import div_32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // One extra bit so the shifted remainder never overflows before the compare.
    assign shifted  = {rem, dividend_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = (shifted >= {1'b0, divisor});
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_32.sv
// div_32: signed/unsigned 32-bit divider, one restoring step per cycle, results registered on DONE.
// Define DIV_32_DZ_DETECT_EN to short-circuit a zero divisor and raise dz.
module div_32
    import div_32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] s_mag;
    logic [WIDTH-1:0] t_mag;
    logic             q_bit;
    logic             sgn_q;
    logic             s_neg;
    logic             t_neg;
    logic             byp;
    logic             accept;
    logic             skip_calc;

    // The cycle showing done=1 is still the end of the previous divide, so start is refused there.
    assign accept = (state == IDLE) && start && !done;
    assign s_mag  = (sgn && s[WIDTH-1]) ? -s : s;
    assign t_mag  = (sgn && t[WIDTH-1]) ? -t : t;

`ifdef DIV_32_DZ_DETECT_EN
    assign skip_calc = (t == '0);
`else
    assign skip_calc = 1'b0;
`endif

    div_32_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem         (rem),
        .dividend_bit(dvd[WIDTH-1]),
        .divisor     (dsr),
        .rem_next    (rem_next),
        .q_bit       (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = skip_calc ? FIX : CALC;
            CALC: if (cnt == '0) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            dvd   <= '0;
            dsr   <= '0;
            rem   <= '0;
            quo   <= '0;
            sgn_q <= 1'b0;
            s_neg <= 1'b0;
            t_neg <= 1'b0;
            byp   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd   <= s_mag;
                        dsr   <= t_mag;
                        rem   <= skip_calc ? s : '0;
                        quo   <= skip_calc ? '1 : '0;
                        cnt   <= CNT_W'(WIDTH - 1);
                        sgn_q <= sgn;
                        s_neg <= s[WIDTH-1];
                        t_neg <= t[WIDTH-1];
                        byp   <= skip_calc;
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= {quo[WIDTH-2:0], q_bit};
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIX: begin
                    // Truncating division: quotient sign from the operand signs, remainder follows the dividend.
                    if (!byp && sgn_q && (s_neg ^ t_neg)) quo <= -quo;
                    if (!byp && sgn_q && s_neg)           rem <= -rem;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_32_DZ_DETECT_EN
            dz        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) busy <= 1'b1;
            if (state == DONE) begin
                busy      <= 1'b0;
                done      <= 1'b1;
                quotient  <= quo;
                remainder <= rem;
`ifdef DIV_32_DZ_DETECT_EN
                dz        <= byp;
`endif
            end
        end
    end

`ifndef DIV_32_DZ_DETECT_EN
    assign dz = 1'b0;
`endif

endmodule

// File: tb/tb_div_32.sv
// Self-checking bench for div_32: directed corner cases plus random signed/unsigned divides against an arithmetic model.
module tb_div_32;

    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sgn;
    logic [31:0] s;
    logic [31:0] t;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_32 dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sgn      (sgn),
        .s        (s),
        .t        (t),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .dz       (dz)
    );

    // Truncating division in 64-bit arithmetic so -2^31 / -1 cannot trap.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, sq, sr;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        sq = sa / sb;
        sr = sa % sb;
        q  = sq[31:0];
        r  = sr[31:0];
    endfunction

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg);
        @(negedge clk);
        if (done) @(negedge clk);
        s     = a;
        t     = b;
        sgn   = sg;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b, input logic sg);
        int          lat;
        logic [31:0] eq, er;
        model(a, b, sg, eq, er);
        issue(a, b, sg);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b expected 1", name, busy); end
        wait_done(lat);
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT); end
        checks++;
        if (quotient !== eq) begin errors++; $display("FAIL %s quotient: got %h expected %h", name, quotient, eq); end
        checks++;
        if (remainder !== er) begin errors++; $display("FAIL %s remainder: got %h expected %h", name, remainder, er); end
        checks++;
        if (dz !== 1'b0) begin errors++; $display("FAIL %s dz: got %b expected 0", name, dz); end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s pulse: got done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sgn = 1'b0; s = '0; t = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, dz} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b expected 000", {busy, done, dz}); end
        checks++;
        if (quotient !== 32'h0) begin errors++; $display("FAIL reset quotient: got %h expected 0", quotient); end
        checks++;
        if (remainder !== 32'h0) begin errors++; $display("FAIL reset remainder: got %h expected 0", remainder); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_div("udiv_100_7", 32'd100, 32'd7, 1'b0);
        run_div("sdiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1);
        run_div("sdiv_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1);
        run_div("udiv_max_16", 32'hFFFFFFFF, 32'h10, 1'b0);
        run_div("sdiv_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1);
        run_div("udiv_small_big", 32'd5, 32'hFFFFFFFF, 1'b0);
    endtask

    task automatic test_hold();
        logic [31:0] eq, er;
        model(32'd1000, 32'd33, 1'b0, eq, er);
        run_div("hold_setup", 32'd1000, 32'd33, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (quotient !== eq || remainder !== er) begin
            errors++; $display("FAIL hold: got %h/%h expected %h/%h", quotient, remainder, eq, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        sg;
        for (int i = 0; i < 24; i++) begin
            a  = $urandom;
            b  = $urandom;
            sg = 1'($urandom_range(0, 1));
            if (i % 3 == 0) b = $urandom_range(1, 255);
            if (i % 8 == 5) b = 32'hFFFFFFFF;
            if (b == 32'h0) b = 32'd1;
            run_div("random", a, b, sg);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        issue(32'h1234, 32'h0, 1'b0);
        wait_done(lat);
`ifdef DIV_32_DZ_DETECT_EN
        checks++;
        if (lat != 2) begin errors++; $display("FAIL dz latency: got %0d expected 2", lat); end
        checks++;
        if (dz !== 1'b1) begin errors++; $display("FAIL dz flag: got %b expected 1", dz); end
        checks++;
        if (quotient !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz quotient: got %h expected ffffffff", quotient); end
        checks++;
        if (remainder !== 32'h1234) begin errors++; $display("FAIL dz remainder: got %h expected 1234", remainder); end
`else
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL dz latency: got %0d expected %0d", lat, LAT); end
        checks++;
        if (dz !== 1'b0) begin errors++; $display("FAIL dz flag: got %b expected 0", dz); end
`endif
    endtask

    task automatic test_start_while_busy();
        int lat;
        int extra;
        issue(32'd1000, 32'd9, 1'b0);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done) begin lat = n; break; end
            if (n == 10) begin
                s = 32'hFFFFFF00; t = 32'd3; sgn = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL busy_start latency: got %0d expected %0d", lat, LAT); end
        checks++;
        if (quotient !== 32'd111 || remainder !== 32'd1) begin
            errors++; $display("FAIL busy_start result: got %h/%h expected 0000006f/00000001", quotient, remainder);
        end
        extra = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL busy_start extra done: got %0d expected 0", extra); end
    endtask

    task automatic test_start_in_done();
        int lat;
        int extra;
        issue(32'd50, 32'd5, 1'b0);
        wait_done(lat);
        s = 32'd7; t = 32'd1; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL done_start busy: got %b expected 0", busy); end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        checks++;
        if (extra != 0 || quotient !== 32'd10) begin
            errors++; $display("FAIL done_start: got done_count=%0d q=%h expected 0 0000000a", extra, quotient);
        end
    endtask

    task automatic test_reset_abort();
        int          lat;
        logic [31:0] eq, er;
        issue(32'd12345, 32'd67, 1'b1);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, dz} !== 3'b000 || quotient !== 32'h0 || remainder !== 32'h0) begin
            errors++;
            $display("FAIL abort outputs: got b=%b d=%b z=%b q=%h r=%h expected all 0", busy, done, dz, quotient, remainder);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        s = 32'hFFFF0000; t = 32'd7; sgn = 1'b1; start = 1'b1;
        model(32'hFFFF0000, 32'd7, 1'b1, eq, er);
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort restart busy: got %b expected 1", busy); end
        wait_done(lat);
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL abort restart latency: got %0d expected %0d", lat, LAT); end
        checks++;
        if (quotient !== eq || remainder !== er) begin
            errors++; $display("FAIL abort restart result: got %h/%h expected %h/%h", quotient, remainder, eq, er);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_random();
        test_div_zero();
        test_start_while_busy();
        test_start_in_done();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_32.md
DIV_32 -- requirements
Module: div_32

Interface
REQ-001 WIDTH, 32, operand and result width in bits; only 32 is verified.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a divide; sampled only in IDLE.
REQ-005 sgn  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
REQ-006 s  input  WIDTH  dividend; captured with start.
REQ-007 t  input  WIDTH  divisor; captured with start.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse when results become valid.
REQ-010 quotient  output  WIDTH  result for LO.
REQ-011 remainder  output  WIDTH  result for HI.
REQ-012 dz  output  1  divide-by-zero flag, valid with done.

Function
REQ-013 The block SHALL use the states IDLE, CALC, FIX and DONE.
REQ-014 IDLE -> CALC on start=1: latch the operands and sgn, convert signed operands to magnitudes, clear the partial remainder, and load the iteration counter with WIDTH-1.
REQ-015 CALC SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH cycles, then go to FIX.
REQ-016 FIX SHALL negate the quotient when sgn=1 and the operand signs differ, and SHALL negate the remainder when sgn=1 and the dividend is negative; it then goes to DONE.
REQ-017 DONE SHALL drive done=1 and busy=0 for one cycle and return to IDLE.
REQ-018 Latency SHALL be WIDTH+2 cycles (34 at default) from the start-accept edge to the edge that asserts done.
REQ-019 Remainder sign SHALL follow the dividend, and |remainder| < |divisor| for a nonzero divisor (truncating division).
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no flag.
REQ-021 start while busy=1 SHALL be ignored, and the captured operands SHALL NOT change.
REQ-022 start asserted in the DONE cycle SHALL be ignored; it is accepted only in IDLE.
REQ-023 quotient, remainder and dz SHALL hold their values from done until the next accepted start's DONE.

Reset
REQ-024 reset=1 SHALL immediately force IDLE, busy=0, done=0, dz=0, quotient=0, remainder=0, and clear the counter.
REQ-025 reset during CALC or FIX SHALL abort the divide, produce no done pulse, and accept a new start on the first clk edge after release.

Configuration
REQ-026 Macro DIV_32_DZ_DETECT_EN.
REQ-027 When the macro is defined, t=0 at start SHALL branch IDLE -> DONE, with done two cycles after accept (via one FIX cycle), dz=1, quotient=0xFFFFFFFF, and remainder=s.
REQ-028 When the macro is undefined, t=0 SHALL run the full WIDTH+2 latency, dz SHALL be tied 0, and the results SHALL be whatever the algorithm produces.

Structure
REQ-029 Package div_32_pkg SHALL hold the state enumeration typedef, the default WIDTH constant, and the counter-width constant.
REQ-030 Sub-module div_32_step SHALL implement one combinational restoring step: partial remainder and dividend bit in, next remainder and quotient bit out.
REQ-031 Sign conversion, the state machine and result registers SHALL live in div_32.

Verification
REQ-032 Unsigned: s=100, t=7, sgn=0 -> done at cycle 34, quotient=14, remainder=2, dz=0.
REQ-033 Signed: s=0xFFFFFFF9 (-7), t=2, sgn=1 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
REQ-034 Overflow: s=0x80000000, t=0xFFFFFFFF, sgn=1 -> quotient=0x80000000, remainder=0; then unsigned 0xFFFFFFFF/0x10 -> quotient=0x0FFFFFFF, remainder=0xF.
REQ-035 Divide-by-zero, macro defined: s=0x1234, t=0 -> done 2 cycles after accept, dz=1, quotient=0xFFFFFFFF, remainder=0x1234; macro undefined -> done at cycle 34, dz=0.
REQ-036 start pulsed at cycle 10 of a busy divide with different operands -> the first result is unchanged, and no second done pulse occurs.
REQ-037 reset asserted at cycle 15 of CALC -> all outputs 0 at once, no done pulse; a start after release gives a correct result at 34 cycles.
